aes_sbox_sched: RTL and testbench
=================================

Name: aes_sbox_sched

Overview:
- Shares a small pool of forward S-box instances (`aes_sbox`, 8-bit in/out, combinational) between two requesters: the round datapath (SubBytes, 128-bit state) and key expansion (SubWord, 32-bit word).
- Arbitrates between the two requesters.
- Time-multiplexes the requested bytes through `NUM_SBOX` lanes.
- Returns the substituted block through a valid/ready handshake.
- Sits between the round controller / key scheduler and the S-box LUTs, so area scales with `NUM_SBOX`.

Parameters:
- NUM_SBOX, 4, number of `aes_sbox` instances. Legal values: 1, 2, 4, 8, 16. Any other value is a compile-time error.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- st_valid  in  1  state request valid
- st_ready  out  1  state request accepted this cycle
- st_data  in  128  state bytes; byte i = st_data[8i+7:8i]
- st_out_valid  out  1  substituted state available
- st_out_ready  in  1  consumer takes the state result
- st_out_data  out  128  SubBytes(st_data), same byte mapping
- key_valid  in  1  key word request valid
- key_ready  out  1  key request accepted this cycle
- key_data  in  32  word bytes; byte i = key_data[8i+7:8i]
- key_out_valid  out  1  substituted word available
- key_out_ready  in  1  consumer takes the key result
- key_out_data  out  32  SubWord(key_data)
- busy  out  1  high when FSM is not in IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- FSM states: IDLE, BUSY, DONE.
- Registers: grant owner `own` (ST/KEY), last-served pointer `last`, byte counter `idx` (0..15), 128-bit result buffer, latched input buffer.
- Arbitration (IDLE only):
  - Only st_valid set: grant ST.
  - Only key_valid set: grant KEY.
  - Both set: grant the requester not equal to `last`.
  - `last` resets to ST, so KEY wins the first conflict after reset.
- Ready signals:
  - st_ready = (state==IDLE) & grant==ST & st_valid.
  - key_ready = (state==IDLE) & grant==KEY & key_valid.
  - Ready may depend combinationally on valid. Never both high in the same cycle.
- Acceptance edge (valid & ready): latch the data, set `own` and `last`, idx=0, go to BUSY.
- BUSY, each cycle:
  - Lanes j = 0..NUM_SBOX-1 substitute byte idx+j of the latched data; results are written into the buffer at the same positions.
  - idx += NUM_SBOX.
  - Bytes per job: NB = 16 (ST) or 4 (KEY).
  - For KEY with NUM_SBOX > 4, lanes 4 and above are unused and must not write.
  - When idx + NUM_SBOX >= NB, go to DONE on that edge.
- Latency from acceptance edge to out_valid high:
  - ST: 16/NUM_SBOX cycles.
  - KEY: max(1, 4/NUM_SBOX) cycles.
- DONE:
  - The owner's out_valid is high. The other requester's out_valid stays low.
  - Output data is held stable until out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid drops next cycle.
- No overlap of jobs. A new request cannot be accepted in the cycle its predecessor's result is taken; the earliest next acceptance is the following cycle.
- Pending requests that are not granted wait with valid held. The requester must keep its data stable until ready.
- Reset (any state, including mid-BUSY or DONE):
  - state=IDLE, `last`=ST, idx=0.
  - st_out_valid=0, key_out_valid=0, busy=0.
  - st_out_data=0, key_out_data=0.
  - The in-flight job is discarded with no partial result.
- Ready outputs are 0 during reset cycles.

Test Plan:
- Single ST job, NUM_SBOX=4: st_data=128'h193DE3BEA0F4E22B9AC68D2AE9F84808 -> st_out_data=128'hD42711AEE0BF98F1B8B45DE51E415230, with st_out_valid high exactly 4 cycles after acceptance.
- Single KEY job: key_data=32'hCF4F3C09 -> key_out_data=32'h8A84EB01, with latency 1 (NUM_SBOX=4), 4 (NUM_SBOX=1) and 1 (NUM_SBOX=16). Also all-zero input -> 32'h63636363.
- Simultaneous requests after reset: st_valid and key_valid both held high -> KEY served first, ST second. Re-raise both -> KEY served again, since `last`=ST after the ST job.
- Backpressure: hold st_out_ready=0 for 10 cycles in DONE -> st_out_data stable, busy=1, key_ready=0 throughout. Raise st_out_ready -> IDLE next cycle.
- Reset mid-BUSY: assert rst_n=0 two cycles into an ST job (NUM_SBOX=2) -> all outputs 0, no st_out_valid. A fresh job after reset returns the correct 128-bit result.
- Exhaustive lanes: 16 ST jobs covering bytes 8'h00..8'hFF across all byte positions -> every byte matches the FIPS-197 S-box (e.g. 8'h53 -> 8'hED, 8'hFF -> 8'h16) for each legal NUM_SBOX.

Source files
------------

// File: rtl/aes_sbox_sched.sv
// rtl/aes_sbox_sched.sv - shared AES forward S-box pool for SubBytes and SubWord
//
// aes_sbox: combinational FIPS-197 forward S-box lookup.
//   a  in  8   input byte
//   y  out 8   substituted byte
//
// aes_sbox_sched: arbitrates between a 128-bit state requester and a 32-bit
// key-word requester, pushes the latched bytes through NUM_SBOX S-box lanes
// per cycle and returns the substituted block on a valid/ready handshake.
//   clk            in   1    rising-edge clock
//   rst_n          in   1    synchronous active-low reset
//   st_valid       in   1    state request valid
//   st_ready       out  1    state request accepted this cycle
//   st_data        in   128  state bytes, byte i = st_data[8i+7:8i]
//   st_out_valid   out  1    substituted state available
//   st_out_ready   in   1    consumer takes the state result
//   st_out_data    out  128  SubBytes(st_data)
//   key_valid      in   1    key word request valid
//   key_ready      out  1    key request accepted this cycle
//   key_data       in   32   word bytes, byte i = key_data[8i+7:8i]
//   key_out_valid  out  1    substituted word available
//   key_out_ready  in   1    consumer takes the key result
//   key_out_data   out  32   SubWord(key_data)
//   busy           out  1    high whenever the scheduler is not idle

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Entry 0 sits in the top byte, so entry a starts at bit 8*(255-a)+7.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;

    assign base = {~a, 3'b111};
    assign y    = SBOX_TABLE[base -: 8];
endmodule

module aes_sbox_sched #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_data,
    output logic         key_out_valid,
    input  logic         key_out_ready,
    output logic [31:0]  key_out_data,
    output logic         busy
);
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
        NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
        $error("aes_sbox_sched: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_ST,
        OWN_KEY
    } owner_t;

    state_t       state;
    owner_t       own;
    owner_t       last;
    logic [3:0]   idx;
    logic [127:0] in_buf;
    logic [127:0] res_buf;
    logic [127:0] res_next;
    logic         grant_key;
    logic         idle;
    logic [4:0]   nb;
    logic         job_last;

    logic [3:0]   lane_pos [NUM_SBOX];
    logic [7:0]   lane_in  [NUM_SBOX];
    logic [7:0]   lane_out [NUM_SBOX];

    // On a conflict the requester that was not served last wins; since last
    // resets to ST, the key scheduler wins the first conflict.
    assign grant_key = key_valid & (~st_valid | (last == OWN_ST));
    assign idle      = (state == S_IDLE);

    // Ready is forced low while reset is asserted, even before the state
    // register has been cleared by the first reset edge.
    assign st_ready  = rst_n & idle & st_valid & ~grant_key;
    assign key_ready = rst_n & idle & grant_key;
    assign busy      = ~idle;

    // Lane j handles byte idx+j. The 4-bit sum never wraps for a live lane:
    // ST keeps idx+j <= 15, and KEY with more than 4 lanes only runs at idx 0.
    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
        assign lane_pos[j] = idx + 4'(j);
        assign lane_in[j]  = in_buf[{lane_pos[j], 3'b000} +: 8];

        aes_sbox u_sbox (
            .a (lane_in[j]),
            .y (lane_out[j])
        );
    end

    always_comb begin
        res_next = res_buf;
        for (int j = 0; j < NUM_SBOX; j++) begin
            // A key word only has 4 bytes; upper lanes stay out of the buffer.
            if (own == OWN_ST || j < 4) begin
                res_next[{lane_pos[j], 3'b000} +: 8] = lane_out[j];
            end
        end
    end

    assign nb       = (own == OWN_ST) ? 5'd16 : 5'd4;
    assign job_last = ({1'b0, idx} + 5'(NUM_SBOX)) >= nb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            own           <= OWN_ST;
            last          <= OWN_ST;
            idx           <= 4'd0;
            in_buf        <= '0;
            res_buf       <= '0;
            st_out_valid  <= 1'b0;
            st_out_data   <= '0;
            key_out_valid <= 1'b0;
            key_out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (st_ready) begin
                        in_buf <= st_data;
                        own    <= OWN_ST;
                        last   <= OWN_ST;
                        idx    <= 4'd0;
                        state  <= S_BUSY;
                    end else if (key_ready) begin
                        in_buf <= {96'd0, key_data};
                        own    <= OWN_KEY;
                        last   <= OWN_KEY;
                        idx    <= 4'd0;
                        state  <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    res_buf <= res_next;
                    if (job_last) begin
                        state <= S_DONE;
                        // Results land in the output registers on the final
                        // lane pass so they are stable for the whole DONE phase.
                        if (own == OWN_ST) begin
                            st_out_data  <= res_next;
                            st_out_valid <= 1'b1;
                        end else begin
                            key_out_data  <= res_next[31:0];
                            key_out_valid <= 1'b1;
                        end
                    end else begin
                        idx <= idx + 4'(NUM_SBOX);
                    end
                end

                S_DONE: begin
                    if (own == OWN_ST && st_out_ready) begin
                        st_out_valid <= 1'b0;
                        idx          <= 4'd0;
                        state        <= S_IDLE;
                    end else if (own == OWN_KEY && key_out_ready) begin
                        key_out_valid <= 1'b0;
                        idx           <= 4'd0;
                        state         <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_sbox_sched.sv
// tb/tb_aes_sbox_sched.sv - bench for aes_sbox_sched across all legal NUM_SBOX values
//
// Five instances (NUM_SBOX = 4, 1, 2, 8, 16) each get their own handshake
// signals; the reference S-box is derived from GF(2^8) inversion plus the
// affine transform.

module tb_aes_sbox_sched;
    localparam int NI = 5;

    function automatic int ns_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_valid      [NI];
    logic         st_ready      [NI];
    logic [127:0] st_data       [NI];
    logic         st_out_valid  [NI];
    logic         st_out_ready  [NI];
    logic [127:0] st_out_data   [NI];
    logic         key_valid     [NI];
    logic         key_ready     [NI];
    logic [31:0]  key_data      [NI];
    logic         key_out_valid [NI];
    logic         key_out_ready [NI];
    logic [31:0]  key_out_data  [NI];
    logic         busy          [NI];

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] ref_sb [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_sbox_sched #(.NUM_SBOX(ns_of(g))) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .st_valid      (st_valid[g]),
            .st_ready      (st_ready[g]),
            .st_data       (st_data[g]),
            .st_out_valid  (st_out_valid[g]),
            .st_out_ready  (st_out_ready[g]),
            .st_out_data   (st_out_data[g]),
            .key_valid     (key_valid[g]),
            .key_ready     (key_ready[g]),
            .key_data      (key_data[g]),
            .key_out_valid (key_out_valid[g]),
            .key_out_ready (key_out_ready[g]),
            .key_out_data  (key_out_data[g]),
            .busy          (busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic void build_ref();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'd0;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'd1) inv = 8'(b);
            ref_sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input bit is_key);
        logic [127:0] r = '0;
        for (int i = 0; i < (is_key ? 4 : 16); i++) r[8*i +: 8] = ref_sb[d[8*i +: 8]];
        return r;
    endfunction

    function automatic int lat_of(input int k, input bit is_key);
        int ns = ns_of(k);
        if (is_key) return (ns >= 4) ? 1 : 4 / ns;
        return 16 / ns;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_accept(input int k, input bit is_key, input string name);
        int cnt = 0;
        logic rdy;
        #1;
        rdy = is_key ? key_ready[k] : st_ready[k];
        while (!rdy && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
            rdy = is_key ? key_ready[k] : st_ready[k];
        end
        n_checks++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL %s accept_timeout: ready=%b required 1", name, rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_result(input int k, input bit is_key, input logic [127:0] exp,
                               input bit bp, input string name);
        int cnt = 0;
        logic ov = 1'b0;
        logic [127:0] od;
        int lat = lat_of(k, is_key);
        while (!ov && cnt < 64) begin
            @(posedge clk); #1;
            cnt++;
            ov = is_key ? key_out_valid[k] : st_out_valid[k];
        end
        n_checks++;
        if (!ov) begin
            n_fail++;
            $display("FAIL %s result_timeout: out_valid=%b required 1", name, ov);
        end else if (cnt != lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles required %0d", name, cnt, lat);
        end
        od = is_key ? {96'd0, key_out_data[k]} : st_out_data[k];
        n_checks++;
        if (od !== exp) begin
            n_fail++;
            $display("FAIL %s data: got %h required %h", name, od, exp);
        end
        n_checks++;
        if ((is_key ? st_out_valid[k] : key_out_valid[k]) !== 1'b0 ||
            st_ready[k] !== 1'b0 || key_ready[k] !== 1'b0 || busy[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_side: other_valid=%b st_ready=%b key_ready=%b busy=%b required 0 0 0 1",
                     name, is_key ? st_out_valid[k] : key_out_valid[k],
                     st_ready[k], key_ready[k], busy[k]);
        end
        if (bp) begin
            repeat ($urandom_range(1, 4)) begin
                @(posedge clk); #1;
                n_checks++;
                if ((is_key ? key_out_valid[k] : st_out_valid[k]) !== 1'b1 ||
                    (is_key ? {96'd0, key_out_data[k]} : st_out_data[k]) !== exp) begin
                    n_fail++;
                    $display("FAIL %s hold: valid=%b data=%h required 1 %h", name,
                             is_key ? key_out_valid[k] : st_out_valid[k],
                             is_key ? {96'd0, key_out_data[k]} : st_out_data[k], exp);
                end
            end
            if (is_key) key_out_ready[k] = 1'b1; else st_out_ready[k] = 1'b1;
        end
        @(posedge clk); #1;
        n_checks++;
        if ((is_key ? key_out_valid[k] : st_out_valid[k]) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid_drop: got 1 required 0", name);
        end
    endtask

    task automatic run_job(input int k, input bit is_key, input logic [127:0] data,
                           input logic [127:0] exp, input bit bp, input string name);
        if (is_key) begin
            key_data[k] = data[31:0]; key_valid[k] = 1'b1; key_out_ready[k] = !bp;
        end else begin
            st_data[k] = data; st_valid[k] = 1'b1; st_out_ready[k] = !bp;
        end
        wait_accept(k, is_key, name);
        if (is_key) key_valid[k] = 1'b0; else st_valid[k] = 1'b0;
        wait_result(k, is_key, exp, bp, name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin st_valid[k] = 1'b1; key_valid[k] = 1'b1; end
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (st_ready[k] !== 1'b0 || key_ready[k] !== 1'b0 || st_out_valid[k] !== 1'b0 ||
                key_out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
                st_out_data[k] !== 128'd0 || key_out_data[k] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: rdy=%b%b ov=%b%b busy=%b sd=%h kd=%h required all 0",
                         k, st_ready[k], key_ready[k], st_out_valid[k], key_out_valid[k],
                         busy[k], st_out_data[k], key_out_data[k]);
            end
        end
        for (int k = 0; k < NI; k++) begin st_valid[k] = 1'b0; key_valid[k] = 1'b0; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        run_job(0, 1'b0, 128'h193DE3BEA0F4E22B9AC68D2AE9F84808,
                128'hD42711AEE0BF98F1B8B45DE51E415230, 1'b0, "st_vector");
        run_job(0, 1'b1, 128'hCF4F3C09, 128'h8A84EB01, 1'b0, "key_vector_n4");
        run_job(1, 1'b1, 128'hCF4F3C09, 128'h8A84EB01, 1'b0, "key_vector_n1");
        run_job(4, 1'b1, 128'hCF4F3C09, 128'h8A84EB01, 1'b0, "key_vector_n16");
        run_job(0, 1'b1, 128'h0, 128'h63636363, 1'b0, "key_zero");
        run_job(3, 1'b0, {16{8'h53}}, {16{8'hED}}, 1'b0, "st_53_n8");
        run_job(2, 1'b0, {16{8'hFF}}, {16{8'h16}}, 1'b0, "st_ff_n2");
    endtask

    task automatic test_conflict();
        logic [127:0] sd;
        logic [31:0]  kd;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            sd = {$urandom, $urandom, $urandom, $urandom};
            kd = $urandom;
            st_data[0] = sd; key_data[0] = kd;
            st_out_ready[0] = 1'b1; key_out_ready[0] = 1'b1;
            st_valid[0] = 1'b1; key_valid[0] = 1'b1;
            #1;
            n_checks++;
            if (key_ready[0] !== 1'b1 || st_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL conflict_grant[%0d]: key_ready=%b st_ready=%b required 1 0",
                         r, key_ready[0], st_ready[0]);
            end
            @(posedge clk); #1;
            key_valid[0] = 1'b0;
            wait_result(0, 1'b1, ref_sub({96'd0, kd}, 1'b1), 1'b0, "conflict_key");
            wait_accept(0, 1'b0, "conflict_st_accept");
            st_valid[0] = 1'b0;
            wait_result(0, 1'b0, ref_sub(sd, 1'b0), 1'b0, "conflict_st");
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] sd;
        logic [127:0] exp;
        logic [31:0]  kd;
        sd  = {$urandom, $urandom, $urandom, $urandom};
        kd  = $urandom;
        exp = ref_sub(sd, 1'b0);
        st_data[0] = sd; st_valid[0] = 1'b1; st_out_ready[0] = 1'b0;
        wait_accept(0, 1'b0, "bp_accept");
        st_valid[0] = 1'b0;
        repeat (lat_of(0, 1'b0)) begin @(posedge clk); #1; end
        key_data[0] = kd; key_valid[0] = 1'b1; key_out_ready[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (st_out_valid[0] !== 1'b1 || st_out_data[0] !== exp ||
                busy[0] !== 1'b1 || key_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: ov=%b data=%h busy=%b key_ready=%b required 1 %h 1 0",
                         c, st_out_valid[0], st_out_data[0], busy[0], key_ready[0], exp);
            end
            @(posedge clk); #1;
        end
        st_out_ready[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (st_out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || key_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: ov=%b busy=%b key_ready=%b required 0 0 1",
                     st_out_valid[0], busy[0], key_ready[0]);
        end
        @(posedge clk); #1;
        key_valid[0] = 1'b0;
        wait_result(0, 1'b1, ref_sub({96'd0, kd}, 1'b1), 1'b0, "bp_key");
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] sd;
        sd = {$urandom, $urandom, $urandom, $urandom};
        st_data[2] = sd; st_valid[2] = 1'b1; st_out_ready[2] = 1'b1;
        wait_accept(2, 1'b0, "rst_mid_accept");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (st_out_valid[2] !== 1'b0 || busy[2] !== 1'b0 || st_ready[2] !== 1'b0 ||
            st_out_data[2] !== 128'd0 || key_out_data[2] !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_state: ov=%b busy=%b st_ready=%b sd=%h kd=%h required all 0",
                     st_out_valid[2], busy[2], st_ready[2], st_out_data[2], key_out_data[2]);
        end
        st_valid[2] = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (st_out_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet[%0d]: ov=%b busy=%b required 0 0",
                         c, st_out_valid[2], busy[2]);
            end
        end
        sd = {$urandom, $urandom, $urandom, $urandom};
        run_job(2, 1'b0, sd, ref_sub(sd, 1'b0), 1'b0, "rst_mid_fresh");
    endtask

    task automatic test_exhaustive();
        logic [127:0] d;
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(j * 16 + ((i + j) % 16));
                run_job(k, 1'b0, d, ref_sub(d, 1'b0), 1'b0, "exhaustive");
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        bit is_key;
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 10; n++) begin
                d      = {$urandom, $urandom, $urandom, $urandom};
                is_key = 1'($urandom_range(0, 1));
                if (is_key) d[127:32] = '0;
                run_job(k, is_key, d, ref_sub(d, is_key), 1'($urandom_range(0, 1)), "random");
            end
        end
    endtask

    initial begin
        build_ref();
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            st_valid[k] = 1'b0; st_data[k] = '0; st_out_ready[k] = 1'b1;
            key_valid[k] = 1'b0; key_data[k] = '0; key_out_ready[k] = 1'b1;
        end
        @(posedge clk); #1;
        test_reset();
        test_vectors();
        test_conflict();
        test_backpressure();
        test_reset_mid_busy();
        test_exhaustive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
